// File: rtl/ex_operand_stage.sv
// ID/EX stage register with EX/MEM and MEM/WB operand forwarding, load-use
// hazard detection and bubble insertion; feeds the ALU and EX/MEM register.
module ex_operand_stage #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned REGIDX = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REGIDX-1:0] id_rn_idx,
   input  logic [REGIDX-1:0] id_rm_idx,
   input  logic [REGIDX-1:0] id_rd_idx,
   input  logic [XLEN-1:0]   id_rn_data,
   input  logic [XLEN-1:0]   id_rm_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [3:0]        id_alu_ctrl,
   input  logic              id_alu_src,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              hold,
   input  logic              flush,
   input  logic              mem_reg_write,
   input  logic [REGIDX-1:0] mem_rd_idx,
   input  logic [XLEN-1:0]   mem_result,
   input  logic              wb_reg_write,
   input  logic [REGIDX-1:0] wb_rd_idx,
   input  logic [XLEN-1:0]   wb_result,
   output logic [XLEN-1:0]   a,
   output logic [XLEN-1:0]   b,
   output logic [3:0]        alu_ctrl,
   output logic              ex_valid,
   output logic [REGIDX-1:0] ex_rd_idx,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic [XLEN-1:0]   ex_store_data,
   output logic              load_use_stall
);

   localparam logic [REGIDX-1:0] XZR = {REGIDX{1'b1}};

   typedef struct packed {
      logic              valid;
      logic [REGIDX-1:0] rn_idx;
      logic [REGIDX-1:0] rm_idx;
      logic [REGIDX-1:0] rd_idx;
      logic [XLEN-1:0]   rn_data;
      logic [XLEN-1:0]   rm_data;
      logic [XLEN-1:0]   imm;
      logic [3:0]        alu_ctrl;
      logic              alu_src;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
   } slot_t;

   slot_t             slot_q;
   slot_t             slot_d;
   logic [XLEN-1:0]   fwd_n;
   logic [XLEN-1:0]   fwd_m;

   // EX/MEM result takes precedence over MEM/WB; XZR always reads zero
   function automatic logic [XLEN-1:0] forward(
      input logic [REGIDX-1:0] idx,
      input logic [XLEN-1:0]   stored,
      input logic              m_we,
      input logic [REGIDX-1:0] m_idx,
      input logic [XLEN-1:0]   m_res,
      input logic              w_we,
      input logic [REGIDX-1:0] w_idx,
      input logic [XLEN-1:0]   w_res
   );
      logic [XLEN-1:0] r;
      if (idx == XZR)                  r = '0;
      else if (m_we && (m_idx == idx)) r = m_res;
      else if (w_we && (w_idx == idx)) r = w_res;
      else                             r = stored;
      return r;
   endfunction

   always_comb begin
      fwd_n = forward(slot_q.rn_idx, slot_q.rn_data, mem_reg_write, mem_rd_idx,
                      mem_result, wb_reg_write, wb_rd_idx, wb_result);
      fwd_m = forward(slot_q.rm_idx, slot_q.rm_data, mem_reg_write, mem_rd_idx,
                      mem_result, wb_reg_write, wb_rd_idx, wb_result);
   end

   always_comb begin
      load_use_stall = id_valid && slot_q.valid && slot_q.mem_read &&
                       (slot_q.rd_idx != XZR) &&
                       ((slot_q.rd_idx == id_rn_idx) || (slot_q.rd_idx == id_rm_idx));
   end

   // Next stage contents: flush > hold (with operand refresh) > stall > capture
   always_comb begin
      slot_d = slot_q;
      if (flush) begin
         slot_d = '0;
      end else if (hold) begin
         slot_d.rn_data = fwd_n;
         slot_d.rm_data = fwd_m;
      end else if (load_use_stall || !id_valid) begin
         slot_d = '0;
      end else begin
         slot_d.valid     = 1'b1;
         slot_d.rn_idx    = id_rn_idx;
         slot_d.rm_idx    = id_rm_idx;
         slot_d.rd_idx    = id_rd_idx;
         slot_d.rn_data   = id_rn_data;
         slot_d.rm_data   = id_rm_data;
         slot_d.imm       = id_imm;
         slot_d.alu_ctrl  = id_alu_ctrl;
         slot_d.alu_src   = id_alu_src;
         slot_d.reg_write = id_reg_write;
         slot_d.mem_read  = id_mem_read;
         slot_d.mem_write = id_mem_write;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) slot_q <= '0;
      else     slot_q <= slot_d;
   end

   assign a             = fwd_n;
   assign b             = slot_q.alu_src ? slot_q.imm : fwd_m;
   assign ex_store_data = fwd_m;
   assign alu_ctrl      = slot_q.alu_ctrl;
   assign ex_valid      = slot_q.valid;
   assign ex_rd_idx     = slot_q.rd_idx;
   assign ex_reg_write  = slot_q.reg_write;
   assign ex_mem_read   = slot_q.mem_read;
   assign ex_mem_write  = slot_q.mem_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic
// checked against an instruction-level model of the execute slot.
module tb_ex_operand_stage;
   localparam int unsigned XLEN = 64;

   logic clk = 1'b0;
   logic rst;
   logic id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
   logic [4:0] id_rn_idx, id_rm_idx, id_rd_idx;
   logic [XLEN-1:0] id_rn_data, id_rm_data, id_imm;
   logic [3:0] id_alu_ctrl;
   logic hold, flush;
   logic mem_reg_write, wb_reg_write;
   logic [4:0] mem_rd_idx, wb_rd_idx;
   logic [XLEN-1:0] mem_result, wb_result;
   logic [XLEN-1:0] a, b, ex_store_data;
   logic [3:0] alu_ctrl;
   logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
   logic [4:0] ex_rd_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_operand_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rn_idx(id_rn_idx), .id_rm_idx(id_rm_idx), .id_rd_idx(id_rd_idx),
      .id_rn_data(id_rn_data), .id_rm_data(id_rm_data), .id_imm(id_imm),
      .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .hold(hold), .flush(flush),
      .mem_reg_write(mem_reg_write), .mem_rd_idx(mem_rd_idx), .mem_result(mem_result),
      .wb_reg_write(wb_reg_write), .wb_rd_idx(wb_rd_idx), .wb_result(wb_result),
      .a(a), .b(b), .alu_ctrl(alu_ctrl), .ex_valid(ex_valid), .ex_rd_idx(ex_rd_idx),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
   );

   // The instruction currently sitting in EX, as the model sees it
   typedef struct packed {
      logic valid;
      logic [4:0] rn, rm, rd;
      logic [XLEN-1:0] rn_d, rm_d, imm;
      logic [3:0] ctrl;
      logic src, rw, mr, mw;
   } instr_t;

   instr_t m = '0;

   function automatic logic [XLEN-1:0] operand(input logic [4:0] idx, input logic [XLEN-1:0] stored);
      if (idx == 5'd31) return '0;
      if (mem_reg_write && mem_rd_idx == idx) return mem_result;
      if (wb_reg_write && wb_rd_idx == idx) return wb_result;
      return stored;
   endfunction

   function automatic logic model_stall();
      return id_valid && m.valid && m.mr && m.rd != 5'd31 &&
             (m.rd == id_rn_idx || m.rd == id_rm_idx);
   endfunction

   function automatic instr_t model_next();
      instr_t n;
      n = '0;
      if (rst || flush) n = '0;
      else if (hold) begin
         n = m;
         n.rn_d = operand(m.rn, m.rn_d);
         n.rm_d = operand(m.rm, m.rm_d);
      end else if (!model_stall() && id_valid) begin
         n = '{1'b1, id_rn_idx, id_rm_idx, id_rd_idx, id_rn_data, id_rm_data, id_imm,
               id_alu_ctrl, id_alu_src, id_reg_write, id_mem_read, id_mem_write};
      end
      return n;
   endfunction

   task automatic step();
      instr_t n;
      n = model_next();
      @(posedge clk);
      m = n;
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rd, input logic [XLEN-1:0] rnd,
                         input logic [XLEN-1:0] rmd, input logic [XLEN-1:0] imm,
                         input logic [3:0] ctrl, input logic src, input logic rw,
                         input logic mr, input logic mw);
      id_valid = v; id_rn_idx = rn; id_rm_idx = rm; id_rd_idx = rd;
      id_rn_data = rnd; id_rm_data = rmd; id_imm = imm; id_alu_ctrl = ctrl;
      id_alu_src = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   task automatic set_fwd(input logic mw, input logic [4:0] mi, input logic [XLEN-1:0] mr,
                          input logic ww, input logic [4:0] wi, input logic [XLEN-1:0] wr);
      mem_reg_write = mw; mem_rd_idx = mi; mem_result = mr;
      wb_reg_write = ww; wb_rd_idx = wi; wb_result = wr;
   endtask

   function automatic logic [XLEN-1:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [4:0] rand_idx();
      int unsigned v;
      v = $urandom_range(0, 4);
      return (v == 4) ? 5'd31 : 5'(v);
   endfunction

   task automatic test_reset();
      rst = 1'b1; hold = 1'b0; flush = 1'b0;
      set_id(1'b1, rand_idx(), rand_idx(), rand_idx(), rand64(), rand64(), rand64(),
             4'($urandom_range(0, 15)), 1'($urandom), 1'b1, 1'($urandom), 1'($urandom));
      set_fwd(1'b0, 5'd0, rand64(), 1'b0, 5'd0, rand64());
      step(); step();
      checks++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 ||
          ex_mem_write !== 1'b0 || alu_ctrl !== 4'd0 || ex_rd_idx !== 5'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got v=%b rw=%b mr=%b mw=%b ctrl=%h rd=%0d, expected all 0",
                  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, alu_ctrl, ex_rd_idx);
      end
      checks++;
      if (a !== '0 || b !== '0) begin
         errors++; $display("FAIL reset_ab: got a=%h b=%h, expected 0", a, b);
      end
      rst = 1'b0;
      id_valid = 1'b0;
      step(); step();
      checks++;
      if (ex_valid !== 1'b0 || a !== '0 || b !== '0) begin
         errors++;
         $display("FAIL reset_held: got v=%b a=%h b=%h, expected 0", ex_valid, a, b);
      end
   endtask

   task automatic test_plain_capture();
      set_id(1'b1, 5'd1, 5'd0, 5'd3, 64'd5, 64'h99, 64'd3, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      id_valid = 1'b0;
      #1;
      checks++;
      if (a !== 64'd5 || b !== 64'd3 || alu_ctrl !== 4'd2 || ex_valid !== 1'b1 ||
          ex_rd_idx !== 5'd3 || ex_reg_write !== 1'b1) begin
         errors++;
         $display("FAIL plain_capture: got a=%h b=%h ctrl=%h v=%b rd=%0d rw=%b, expected 5 3 2 1 3 1",
                  a, b, alu_ctrl, ex_valid, ex_rd_idx, ex_reg_write);
      end
   endtask

   task automatic test_forward_priority();
      set_id(1'b1, 5'd4, 5'd4, 5'd6, 64'h11, 64'h22, 64'h0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      id_valid = 1'b0;
      set_fwd(1'b1, 5'd4, 64'hAA, 1'b1, 5'd4, 64'hBB);
      #1;
      checks++;
      if (a !== 64'hAA || b !== 64'hAA || ex_store_data !== 64'hAA) begin
         errors++;
         $display("FAIL fwd_mem_wins: got a=%h b=%h sd=%h, expected aa", a, b, ex_store_data);
      end
      mem_reg_write = 1'b0;
      #1;
      checks++;
      if (a !== 64'hBB) begin
         errors++; $display("FAIL fwd_wb: got a=%h, expected bb", a);
      end
      wb_reg_write = 1'b0;
      #1;
      checks++;
      if (a !== 64'h11 || b !== 64'h22) begin
         errors++; $display("FAIL fwd_none: got a=%h b=%h, expected 11 22", a, b);
      end
   endtask

   task automatic test_xzr();
      set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      set_id(1'b1, 5'd31, 5'd31, 5'd7, 64'h77, 64'h88, 64'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      id_valid = 1'b0;
      set_fwd(1'b1, 5'd31, 64'hFF, 1'b1, 5'd31, 64'hEE);
      #1;
      checks++;
      if (a !== '0 || b !== '0 || ex_store_data !== '0) begin
         errors++; $display("FAIL xzr: got a=%h b=%h sd=%h, expected 0", a, b, ex_store_data);
      end
      set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
   endtask

   task automatic test_load_use();
      // LDUR X2, [X1, #8]
      set_id(1'b1, 5'd1, 5'd31, 5'd2, 64'h1000, 64'h0, 64'd8, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      // ADD X5, X2, X3 with a stale register-file read of X2
      set_id(1'b1, 5'd2, 5'd3, 5'd5, 64'h1234, 64'd7, 64'h0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (load_use_stall !== 1'b1) begin
         errors++; $display("FAIL load_use_detect: got %b, expected 1", load_use_stall);
      end
      step();
      checks++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || load_use_stall !== 1'b0) begin
         errors++;
         $display("FAIL load_use_bubble: got v=%b rw=%b mr=%b stall=%b, expected 0 0 0 0",
                  ex_valid, ex_reg_write, ex_mem_read, load_use_stall);
      end
      set_fwd(1'b1, 5'd2, 64'h1008, 1'b0, 5'd0, '0);
      step();
      id_valid = 1'b0;
      set_fwd(1'b0, 5'd0, '0, 1'b1, 5'd2, 64'hDEAD);
      #1;
      checks++;
      if (a !== 64'hDEAD || b !== 64'd7 || ex_valid !== 1'b1 || ex_rd_idx !== 5'd5) begin
         errors++;
         $display("FAIL load_use_wb_fwd: got a=%h b=%h v=%b rd=%0d, expected dead 7 1 5",
                  a, b, ex_valid, ex_rd_idx);
      end
      set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
   endtask

   task automatic test_hold_flush();
      set_id(1'b1, 5'd6, 5'd7, 5'd8, 64'h100, 64'h200, 64'h0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      set_id(1'b1, 5'd1, 5'd1, 5'd9, 64'h3, 64'h3, 64'h3, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      hold = 1'b1;
      set_fwd(1'b0, 5'd0, '0, 1'b1, 5'd6, 64'h555);
      step();
      wb_reg_write = 1'b0;
      step(); step();
      checks++;
      if (a !== 64'h555 || b !== 64'h200 || ex_valid !== 1'b1 || alu_ctrl !== 4'd6 || ex_rd_idx !== 5'd8) begin
         errors++;
         $display("FAIL hold_refresh: got a=%h b=%h v=%b ctrl=%h rd=%0d, expected 555 200 1 6 8",
                  a, b, ex_valid, alu_ctrl, ex_rd_idx);
      end
      flush = 1'b1;
      step();
      checks++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || a !== '0 || alu_ctrl !== 4'd0) begin
         errors++;
         $display("FAIL flush_over_hold: got v=%b rw=%b a=%h ctrl=%h, expected 0",
                  ex_valid, ex_reg_write, a, alu_ctrl);
      end
      flush = 1'b0; hold = 1'b0;
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd_idx !== 5'd9 || alu_ctrl !== 4'd1) begin
         errors++;
         $display("FAIL capture_after_flush: got v=%b rd=%0d ctrl=%h, expected 1 9 1",
                  ex_valid, ex_rd_idx, alu_ctrl);
      end
      #2 rst = 1'b1;
      m = '0;
      #1;
      checks++;
      if (ex_valid !== 1'b0 || alu_ctrl !== 4'd0 || ex_rd_idx !== 5'd0) begin
         errors++;
         $display("FAIL async_reset: got v=%b ctrl=%h rd=%0d, expected 0", ex_valid, alu_ctrl, ex_rd_idx);
      end
      rst = 1'b0;
      id_valid = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 49) == 0);
         hold  = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 9) == 0);
         set_id(($urandom_range(0, 4) != 0), rand_idx(), rand_idx(), rand_idx(),
                rand64(), rand64(), rand64(), 4'($urandom_range(0, 15)), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
         set_fwd(1'($urandom), rand_idx(), rand64(), 1'($urandom), rand_idx(), rand64());
         if (rst) m = '0;
         #1;
         checks++;
         if (a !== operand(m.rn, m.rn_d) || b !== (m.src ? m.imm : operand(m.rm, m.rm_d)) ||
             ex_store_data !== operand(m.rm, m.rm_d)) begin
            errors++;
            $display("FAIL rand_operands[%0d]: got a=%h b=%h sd=%h, expected a=%h b=%h sd=%h", i,
                     a, b, ex_store_data, operand(m.rn, m.rn_d),
                     (m.src ? m.imm : operand(m.rm, m.rm_d)), operand(m.rm, m.rm_d));
         end
         checks++;
         if (ex_valid !== m.valid || alu_ctrl !== m.ctrl || ex_rd_idx !== m.rd ||
             ex_reg_write !== m.rw || ex_mem_read !== m.mr || ex_mem_write !== m.mw) begin
            errors++;
            $display("FAIL rand_ctrl[%0d]: got v=%b ctrl=%h rd=%0d rw=%b mr=%b mw=%b, expected %b %h %0d %b %b %b",
                     i, ex_valid, alu_ctrl, ex_rd_idx, ex_reg_write, ex_mem_read, ex_mem_write,
                     m.valid, m.ctrl, m.rd, m.rw, m.mr, m.mw);
         end
         checks++;
         if (load_use_stall !== model_stall()) begin
            errors++;
            $display("FAIL rand_stall[%0d]: got %b, expected %b", i, load_use_stall, model_stall());
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_plain_capture();
      test_forward_priority();
      test_xzr();
      test_load_use();
      test_hold_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
